// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes the immediate on the input side and
// buffers {imm, err, tag} in an output register plus one skid entry behind valid/ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic             imm_err,
    output logic [TAG_W-1:0] out_tag
);

    generate
        if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b10
    } state_t;

    function automatic logic [XLEN-1:0] f_sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] f_zext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    logic [XLEN-1:0]  w_imm;
    logic             w_err;
    state_t           r_state;
    state_t           w_next;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [XLEN-1:0]  r_out_imm;
    logic             r_out_err;
    logic [TAG_W-1:0] r_out_tag;
    logic [XLEN-1:0]  r_skid_imm;
    logic             r_skid_err;
    logic [TAG_W-1:0] r_skid_tag;
    logic             w_acc;
    logic             w_drn;
    logic             w_load_in;
    logic             w_load_skid;
    logic             w_shift;

    assign w_acc = in_valid & r_in_ready;
    assign w_drn = r_out_valid & out_ready;

    // Immediate extraction and extension for the instruction on the input side.
    always_comb begin
        w_imm = '0;
        w_err = 1'b0;
        case (imm_src)
            3'b000: w_imm = f_sext32({{20{instr[31]}}, instr[31:20]});
            3'b001: w_imm = f_sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            3'b010: w_imm = f_sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                      instr[11:8], 1'b0});
            3'b011: w_imm = f_sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                      instr[30:21], 1'b0});
            3'b100: w_imm = f_sext32({instr[31:12], 12'h000});
            3'b101: w_imm = f_zext32({27'h0000000, instr[19:15]});
            3'b110: begin
                // RV64 shifts use a 6-bit shamt; RV32 only 5 bits.
                if (XLEN == 64) begin
                    w_imm = f_zext32({26'h0000000, instr[25:20]});
                end else begin
                    w_imm = f_zext32({27'h0000000, instr[24:20]});
                end
            end
            default: begin
                w_imm = '0;
                w_err = 1'b1;
            end
        endcase
    end

    // Next-state and load-enable decode; flush overrides everything except the drain.
    always_comb begin
        w_next      = r_state;
        w_load_in   = 1'b0;
        w_load_skid = 1'b0;
        w_shift     = 1'b0;
        if (flush) begin
            w_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        w_next    = S_ONE;
                        w_load_in = 1'b1;
                    end else begin
                        w_next = S_EMPTY;
                    end
                end
                S_ONE: begin
                    if (w_acc && w_drn) begin
                        w_next    = S_ONE;
                        w_load_in = 1'b1;
                    end else if (w_acc) begin
                        w_next      = S_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_drn) begin
                        w_next = S_EMPTY;
                    end else begin
                        w_next = S_ONE;
                    end
                end
                S_FULL: begin
                    if (w_drn) begin
                        w_next  = S_ONE;
                        w_shift = 1'b1;
                    end else begin
                        w_next = S_FULL;
                    end
                end
                default: w_next = S_EMPTY;
            endcase
        end
    end

    // State register with registered handshake flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (w_next != S_EMPTY);
            r_in_ready  <= (w_next != S_FULL);
        end
    end

    // Output entry: loads only on a direct fill or a shift from the skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_imm <= '0;
            r_out_err <= 1'b0;
            r_out_tag <= '0;
        end else if (w_load_in) begin
            r_out_imm <= w_imm;
            r_out_err <= w_err;
            r_out_tag <= in_tag;
        end else if (w_shift) begin
            r_out_imm <= r_skid_imm;
            r_out_err <= r_skid_err;
            r_out_tag <= r_skid_tag;
        end
    end

    // Skid entry: catches the accept that arrives while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_imm <= '0;
            r_skid_err <= 1'b0;
            r_skid_tag <= '0;
        end else if (w_load_skid) begin
            r_skid_imm <= w_imm;
            r_skid_err <= w_err;
            r_skid_tag <= in_tag;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign imm       = r_out_imm;
    assign imm_err   = r_out_err;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an XLEN=32 instance for handshake/flush/reset
// scenarios and an XLEN=64 instance for the wide formats.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic        err;
        logic [7:0]  tag;
    } ent_t;

    logic        clk;
    logic        rst_n;

    logic        flush32, in_valid32, in_ready32, out_valid32, out_ready32, imm_err32;
    logic [31:0] instr32, imm32;
    logic [2:0]  src32;
    logic [7:0]  in_tag32, out_tag32;

    logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64, imm_err64;
    logic [31:0] instr64;
    logic [63:0] imm64;
    logic [2:0]  src64;
    logic [7:0]  in_tag64, out_tag64;

    ent_t q[$];
    int   n_checks;
    int   n_fail;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32),
        .in_valid(in_valid32), .in_ready(in_ready32),
        .instr(instr32), .imm_src(src32), .in_tag(in_tag32),
        .out_valid(out_valid32), .out_ready(out_ready32),
        .imm(imm32), .imm_err(imm_err32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64),
        .instr(instr64), .imm_src(src64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(out_ready64),
        .imm(imm64), .imm_err(imm_err64), .out_tag(out_tag64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference immediate built with arithmetic shifts and masks.
    function automatic logic [63:0] ref_imm(input int xlen, input logic [31:0] ins,
                                            input logic [2:0] src);
        logic [31:0] sgn;
        logic [31:0] v;
        sgn = $signed(ins) >>> 31;
        v   = 32'h0;
        case (src)
            3'd0: v = $signed(ins) >>> 20;
            3'd1: begin
                v = $signed(ins) >>> 20;
                v = (v & 32'hFFFF_FFE0) | 32'(ins[11:7]);
            end
            3'd2: v = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
                      | (32'(ins[11:8]) << 1);
            3'd3: v = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
                      | (32'(ins[30:21]) << 1);
            3'd4: v = ins & 32'hFFFF_F000;
            3'd5: v = 32'(ins[19:15]);
            3'd6: v = (xlen == 64) ? 32'(ins[25:20]) : 32'(ins[24:20]);
            default: v = 32'h0;
        endcase
        if (xlen == 64) return {{32{v[31]}}, v};
        else            return {32'h0, v};
    endfunction

    // One clock on the 32-bit instance with scoreboard bookkeeping (no comparisons here).
    task automatic tick32(output logic acc, output logic drn, output logic have,
                          output ent_t got, output ent_t exp);
        acc  = in_valid32 && in_ready32;
        drn  = out_valid32 && out_ready32;
        got  = {{32'h0, imm32}, imm_err32, out_tag32};
        exp  = '0;
        have = 1'b0;
        if (drn && (q.size() > 0)) begin
            exp  = q.pop_front();
            have = 1'b1;
        end
        if (flush32) q.delete();
        else if (acc) q.push_back({ref_imm(32, instr32, src32), (src32 == 3'b111), in_tag32});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL rst_valid32 got=%b exp=0", out_valid32); end
        n_checks++; if (imm32 !== 32'h0) begin n_fail++; $display("FAIL rst_imm32 got=%h exp=0", imm32); end
        n_checks++; if (imm_err32 !== 1'b0) begin n_fail++; $display("FAIL rst_err32 got=%b exp=0", imm_err32); end
        n_checks++; if (out_tag32 !== 8'h00) begin n_fail++; $display("FAIL rst_tag32 got=%h exp=0", out_tag32); end
        n_checks++; if (out_valid64 !== 1'b0 || imm64 !== 64'h0) begin n_fail++; $display("FAIL rst_64 got=%b/%h exp=0/0", out_valid64, imm64); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0) begin n_fail++; $display("FAIL rst_release got=rdy%b vld%b exp=rdy1 vld0", in_ready32, out_valid32); end
    endtask

    task automatic test_single;
        logic acc, drn, have;
        ent_t got, exp;
        out_ready32 = 1'b1; in_valid32 = 1'b1;
        instr32 = 32'hFFF00093; src32 = 3'b000; in_tag32 = 8'h11;
        tick32(acc, drn, have, got, exp);
        in_valid32 = 1'b0;
        n_checks++; if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", out_valid32); end
        n_checks++; if (imm32 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL single_imm got=%h exp=ffffffff", imm32); end
        n_checks++; if (imm_err32 !== 1'b0) begin n_fail++; $display("FAIL single_err got=%b exp=0", imm_err32); end
        n_checks++; if (out_tag32 !== 8'h11) begin n_fail++; $display("FAIL single_tag got=%h exp=11", out_tag32); end
        tick32(acc, drn, have, got, exp);
        if (drn) begin n_checks++; if (!have || got !== exp) begin n_fail++; $display("FAIL sb_single got=%h exp=%h have=%0d", got, exp, have); end end
        n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%b exp=0", out_valid32); end
    endtask

    task automatic test_back_to_back;
        logic acc, drn, have;
        ent_t got, exp;
        logic [31:0] ins [3];
        logic [2:0]  srcs [3];
        logic [31:0] exps [3];
        ins[0] = 32'hFE000EE3; srcs[0] = 3'b010; exps[0] = 32'hFFFFFFFC;
        ins[1] = 32'h0010006F; srcs[1] = 3'b011; exps[1] = 32'h00000800;
        ins[2] = 32'h00112223; srcs[2] = 3'b001; exps[2] = 32'h00000004;
        out_ready32 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid32 = 1'b1; instr32 = ins[i]; src32 = srcs[i]; in_tag32 = 8'h40 + 8'(i);
            tick32(acc, drn, have, got, exp);
            if (drn) begin n_checks++; if (!have || got !== exp) begin n_fail++; $display("FAIL sb_b2b got=%h exp=%h have=%0d", got, exp, have); end end
            n_checks++;
            if (out_valid32 !== 1'b1 || imm32 !== exps[i] || out_tag32 !== (8'h40 + 8'(i))) begin
                n_fail++; $display("FAIL b2b_%0d got=v%b imm=%h tag=%h exp=v1 imm=%h tag=%h", i, out_valid32, imm32, out_tag32, exps[i], 8'h40 + 8'(i));
            end
        end
        in_valid32 = 1'b0;
        tick32(acc, drn, have, got, exp);
        if (drn) begin n_checks++; if (!have || got !== exp) begin n_fail++; $display("FAIL sb_b2b_last got=%h exp=%h have=%0d", got, exp, have); end end
        n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got=%b exp=0", out_valid32); end
    endtask

    task automatic test_xlen64;
        logic [31:0] ins [3];
        logic [2:0]  srcs [3];
        logic [63:0] exps [3];
        logic [63:0] e;
        ins[0] = 32'h800000B7; srcs[0] = 3'b100; exps[0] = 64'hFFFFFFFF80000000;
        ins[1] = 32'h03F09093; srcs[1] = 3'b110; exps[1] = 64'h000000000000003F;
        ins[2] = 32'h3000D073; srcs[2] = 3'b101; exps[2] = 64'h0000000000000001;
        out_ready64 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid64 = 1'b1; instr64 = ins[i]; src64 = srcs[i]; in_tag64 = 8'h70 + 8'(i);
            @(posedge clk); #1;
            n_checks++;
            if (out_valid64 !== 1'b1 || imm64 !== exps[i] || imm_err64 !== 1'b0 || out_tag64 !== (8'h70 + 8'(i))) begin
                n_fail++; $display("FAIL x64_%0d got=v%b imm=%h err=%b tag=%h exp imm=%h", i, out_valid64, imm64, imm_err64, out_tag64, exps[i]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            instr64 = $urandom; src64 = 3'($urandom_range(0, 7)); in_tag64 = 8'($urandom);
            e = ref_imm(64, instr64, src64);
            @(posedge clk); #1;
            n_checks++;
            if (imm64 !== e || imm_err64 !== (src64 == 3'b111) || out_tag64 !== in_tag64) begin
                n_fail++; $display("FAIL x64_rand src=%0d instr=%h got=%h err=%b exp=%h", src64, instr64, imm64, imm_err64, e);
            end
        end
        in_valid64 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (out_valid64 !== 1'b0) begin n_fail++; $display("FAIL x64_empty got=%b exp=0", out_valid64); end
    endtask

    task automatic test_backpressure;
        logic acc, drn, have;
        ent_t got, exp;
        logic [63:0] e1;
        int ndr;
        out_ready32 = 1'b0; in_valid32 = 1'b1;
        instr32 = 32'h80000513; src32 = 3'b000; in_tag32 = 8'h01;
        e1 = ref_imm(32, instr32, src32);
        tick32(acc, drn, have, got, exp);
        n_checks++; if (acc !== 1'b1 || in_ready32 !== 1'b1 || out_tag32 !== 8'h01) begin n_fail++; $display("FAIL bp_first got=acc%b rdy%b tag=%h exp=acc1 rdy1 tag=01", acc, in_ready32, out_tag32); end
        instr32 = 32'h12345678; src32 = 3'b011; in_tag32 = 8'h02;
        tick32(acc, drn, have, got, exp);
        n_checks++; if (acc !== 1'b1 || in_ready32 !== 1'b0 || out_tag32 !== 8'h01) begin n_fail++; $display("FAIL bp_second got=acc%b rdy%b tag=%h exp=acc1 rdy0 tag=01", acc, in_ready32, out_tag32); end
        instr32 = 32'hDEADBEEF; src32 = 3'b010; in_tag32 = 8'h03;
        tick32(acc, drn, have, got, exp);
        n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL bp_hold1 got=acc%b exp=acc0", acc); end
        tick32(acc, drn, have, got, exp);
        n_checks++;
        if (acc !== 1'b0 || out_tag32 !== 8'h01 || imm32 !== e1[31:0]) begin
            n_fail++; $display("FAIL bp_hold2 got=acc%b tag=%h imm=%h exp=acc0 tag=01 imm=%h", acc, out_tag32, imm32, e1[31:0]);
        end
        out_ready32 = 1'b1;
        ndr = 0;
        for (int k = 0; k < 6; k++) begin
            tick32(acc, drn, have, got, exp);
            if (acc) in_valid32 = 1'b0;
            if (drn) begin ndr++; n_checks++; if (!have || got !== exp) begin n_fail++; $display("FAIL sb_bp got=%h exp=%h have=%0d", got, exp, have); end end
        end
        n_checks++; if (ndr != 3 || q.size() != 0) begin n_fail++; $display("FAIL bp_count got=%0d drained/%0d left exp=3/0", ndr, q.size()); end
    endtask

    task automatic test_flush;
        logic acc, drn, have;
        ent_t got, exp;
        int ndr;
        out_ready32 = 1'b0; in_valid32 = 1'b1; src32 = 3'b000;
        instr32 = 32'h00500093; in_tag32 = 8'h21;
        tick32(acc, drn, have, got, exp);
        instr32 = 32'h00600093; in_tag32 = 8'h22;
        tick32(acc, drn, have, got, exp);
        instr32 = 32'h00700093; in_tag32 = 8'h23; flush32 = 1'b1;
        tick32(acc, drn, have, got, exp);
        flush32 = 1'b0; in_valid32 = 1'b0;
        n_checks++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin n_fail++; $display("FAIL flush_state got=vld%b rdy%b exp=vld0 rdy1", out_valid32, in_ready32); end
        out_ready32 = 1'b1;
        ndr = 0;
        for (int k = 0; k < 3; k++) begin
            tick32(acc, drn, have, got, exp);
            if (drn) ndr++;
        end
        n_checks++; if (ndr != 0) begin n_fail++; $display("FAIL flush_ghost got=%0d outputs exp=0", ndr); end
        in_valid32 = 1'b1; src32 = 3'b111; instr32 = 32'hFFFFFFFF; in_tag32 = 8'h30;
        tick32(acc, drn, have, got, exp);
        in_valid32 = 1'b0;
        n_checks++;
        if (out_valid32 !== 1'b1 || imm32 !== 32'h0 || imm_err32 !== 1'b1 || out_tag32 !== 8'h30) begin
            n_fail++; $display("FAIL illegal got=v%b imm=%h err=%b tag=%h exp=v1 imm=0 err=1 tag=30", out_valid32, imm32, imm_err32, out_tag32);
        end
        tick32(acc, drn, have, got, exp);
        if (drn) begin n_checks++; if (!have || got !== exp) begin n_fail++; $display("FAIL sb_flush got=%h exp=%h have=%0d", got, exp, have); end end
    endtask

    task automatic test_async_reset;
        logic acc, drn, have;
        ent_t got, exp;
        out_ready32 = 1'b0; in_valid32 = 1'b1; src32 = 3'b000;
        instr32 = 32'hFFF00093; in_tag32 = 8'h51;
        tick32(acc, drn, have, got, exp);
        instr32 = 32'h7FF00093; in_tag32 = 8'h52;
        tick32(acc, drn, have, got, exp);
        in_valid32 = 1'b0;
        n_checks++; if (in_ready32 !== 1'b0) begin n_fail++; $display("FAIL arst_full got=rdy%b exp=rdy0", in_ready32); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", out_valid32); end
        n_checks++; if (imm32 !== 32'h0 || imm_err32 !== 1'b0) begin n_fail++; $display("FAIL arst_imm got=%h/%b exp=0/0", imm32, imm_err32); end
        n_checks++; if (out_tag32 !== 8'h00) begin n_fail++; $display("FAIL arst_tag got=%h exp=00", out_tag32); end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid32 = 1'b1; instr32 = $urandom; src32 = 3'($urandom_range(0, 6)); in_tag32 = 8'h60;
        tick32(acc, drn, have, got, exp);
        in_valid32 = 1'b0; out_ready32 = 1'b1;
        n_checks++; if (out_valid32 !== 1'b1 || out_tag32 !== 8'h60) begin n_fail++; $display("FAIL arst_latency got=v%b tag=%h exp=v1 tag=60", out_valid32, out_tag32); end
        tick32(acc, drn, have, got, exp);
        if (drn) begin n_checks++; if (!have || got !== exp) begin n_fail++; $display("FAIL sb_arst got=%h exp=%h have=%0d", got, exp, have); end end
    endtask

    task automatic test_random;
        logic acc, drn, have;
        ent_t got, exp, cur;
        for (int k = 0; k < 400; k++) begin
            in_valid32  = ($urandom_range(0, 3) != 0);
            instr32     = $urandom;
            src32       = 3'($urandom_range(0, 7));
            in_tag32    = 8'($urandom);
            out_ready32 = ($urandom_range(0, 2) != 0);
            flush32     = ($urandom_range(0, 31) == 0);
            cur = {{32'h0, imm32}, imm_err32, out_tag32};
            if (out_valid32) begin
                n_checks++;
                if (q.size() == 0 || cur !== q[0]) begin n_fail++; $display("FAIL rand_head cyc=%0d got=%h qsize=%0d", k, cur, q.size()); end
            end
            tick32(acc, drn, have, got, exp);
            if (drn) begin n_checks++; if (!have || got !== exp) begin n_fail++; $display("FAIL sb_rand cyc=%0d got=%h exp=%h have=%0d", k, got, exp, have); end end
        end
        flush32 = 1'b0; in_valid32 = 1'b0; out_ready32 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick32(acc, drn, have, got, exp);
            if (drn) begin n_checks++; if (!have || got !== exp) begin n_fail++; $display("FAIL sb_rand_drain got=%h exp=%h have=%0d", got, exp, have); end end
        end
        n_checks++; if (q.size() != 0 || out_valid32 !== 1'b0) begin n_fail++; $display("FAIL rand_leftover got=%0d/v%b exp=0/v0", q.size(), out_valid32); end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b1;
        flush32 = 1'b0; in_valid32 = 1'b0; instr32 = 32'h0; src32 = 3'b000; in_tag32 = 8'h00; out_ready32 = 1'b0;
        flush64 = 1'b0; in_valid64 = 1'b0; instr64 = 32'h0; src64 = 3'b000; in_tag64 = 8'h00; out_ready64 = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_xlen64();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the single-cycle immediate generator. Extracts and extends the immediate from a full 32-bit instruction to XLEN bits and adds CSR-zimm and shift-amount formats plus an illegal-format flag. Uses a valid/ready handshake, a 2-entry skid buffer and a flush input. Sits between the fetch/decode register and the execute-operand mux.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
TAG_W, 8, width of the sideband tag (PC index or ROB id) passed alongside each immediate.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous kill of all buffered entries.
in_valid  input  1  producer has an instruction.
in_ready  output  1  block can accept; registered, not combinationally dependent on out_ready.
instr  input  32  full instruction word.
imm_src  input  3  format select.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  imm/imm_err/out_tag are valid.
out_ready  input  1  consumer accepts.
imm  output  XLEN  extended immediate.
imm_err  output  1  imm_src was 3'b111.
out_tag  output  TAG_W  tag of the entry on the output.

Behaviour:
- Formats, all sign-extended from instr[31] to XLEN unless noted:
  - 000 I: instr[31:20].
  - 001 S: {instr[31:25], instr[11:7]}.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 100 U: {instr[31:12], 12'b0}; bits above 31 sign-extended when XLEN=64.
  - 101 CSR zimm: zero-extend instr[19:15].
  - 110 shamt: zero-extend instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
  - 111: imm=0, imm_err=1. Every other format drives imm_err=0.
- Extension is combinational on the input side. The result, err and tag are captured into the entry.
- Transfer rules: accept when in_valid&&in_ready; drain when out_valid&&out_ready.
- Latency: 1 cycle from accept to out_valid when the output is empty. Throughput is 1 per cycle while out_ready=1.
- Storage: output register (OUT) plus one skid register (SKID). FSM:
  - EMPTY: out_valid=0, in_ready=1. Accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept and drain together -> ONE, OUT loads new entry.
    - Accept without drain -> FULL, new entry to SKID.
    - Drain only -> EMPTY.
  - FULL: out_valid=1, in_ready=0. Drain -> ONE, SKID moves to OUT.
- Order is strictly FIFO. The OUT contents (imm, imm_err, out_tag) do not change while out_valid=1 and out_ready=0.
- flush: next state is EMPTY regardless of state or simultaneous accept/drain. The accept in the flush cycle is discarded. A drain in the flush cycle still completes, since the consumer sampled it.
- Reset (asynchronous, any time, including mid-transfer):
  - state EMPTY, out_valid=0, imm=0, imm_err=0, out_tag=0.
  - in_ready=1 in the first cycle after rst_n deasserts.
  - SKID contents cleared to 0.
- Datapath registers load only on accept or shift, which gives no glitch on held outputs.
- Illegal XLEN (not 32/64): elaboration-time error via generate assertion.

Test Plan:
1. XLEN=32, out_ready=1. instr=0xFFF00093 (addi x1,x0,-1), imm_src=000, tag=0x11 -> next cycle out_valid=1, imm=0xFFFFFFFF, imm_err=0, out_tag=0x11.
2. Back-to-back, out_ready=1. B 0xFE000EE3 src=010 -> 0xFFFFFFFC. J 0x0010006F src=011 -> 0x00000800. S 0x00112223 (sw x1,4(x2)) src=001 -> 0x00000004. Each must appear on consecutive cycles with tags in order.
3. XLEN=64. U 0x800000B7 src=100 -> 0xFFFFFFFF80000000. shamt instr 0x03F09093 (slli x1,x1,63) src=110 -> 0x000000000000003F. CSR 0x3000D073 (csrwi, zimm=1) src=101 -> 0x1.
4. Backpressure. out_ready=0, offer tags 1,2,3 continuously -> tags 1 and 2 accepted, in_ready=0 after second accept, tag 3 held. Raise out_ready -> outputs 1,2,3 in order, no loss or duplication.
5. FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1. Flushed and simultaneous entries never appear. imm_src=111 afterwards -> imm=0, imm_err=1.
6. Drop rst_n asynchronously mid-cycle while FULL -> outputs go to 0 immediately without a clock edge. After release, first accepted instruction appears with 1-cycle latency.
